// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared types and helpers for the clock-divider bank.
//   div_mode_e : per-channel output mode (toggle waveform or pulse strobe)
//   rst_div    : reset divisor of channel i (1 << i), giving div2/4/8/16...
//   num_ch_ok  : legality check for the NUM_CH / CNT_W parameter pair
// -----------------------------------------------------------------------------
package clk_div_pkg;

   typedef enum logic {
      DIV_TOGGLE = 1'b0,
      DIV_PULSE  = 1'b1
   } div_mode_e;

   // Reset divisor for channel i; callers truncate to their counter width.
   function automatic int unsigned rst_div(input int unsigned i);
      return 32'd1 << i;
   endfunction

   // Every channel's reset divisor 2^i must fit in CNT_W bits.
   function automatic bit num_ch_ok(input int num_ch, input int cnt_w);
      return (num_ch >= 1) && (num_ch <= cnt_w);
   endfunction

endpackage

// File: rtl/clk_div_chan.sv
// -----------------------------------------------------------------------------
// clk_div_chan
// One divider channel: counter, active/pending divisor, mode, tick and
// divided output, all registered on clk.
// Ports:
//   clk      in  sole clock, rising edge
//   rst_n    in  asynchronous active-low reset
//   ena      in  count enable
//   sync     in  phase restart (counter/outputs cleared, pending divisor loaded)
//   cfg_we   in  configuration write aimed at this channel
//   cfg_div  in  new divisor (0 = disabled)
//   cfg_mode in  new mode (0 toggle, 1 pulse)
//   tick     out one-cycle strobe at each counter wrap
//   div_out  out divided waveform (toggle) or copy of tick (pulse)
// -----------------------------------------------------------------------------
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int               CNT_W   = 8,
   parameter logic [CNT_W-1:0] RST_DIV = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             sync,
   input  logic             cfg_we,
   input  logic [CNT_W-1:0] cfg_div,
   input  logic             cfg_mode,
   output logic             tick,
   output logic             div_out
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] div_p_q, div_p_d;
   div_mode_e        mode_q, mode_d;
   logic             tick_q, tick_d;
   logic             out_q, out_d;
   logic             wrap;

   always_comb begin
      div_p_d = cfg_we ? cfg_div : div_p_q;
      mode_d  = cfg_we ? div_mode_e'(cfg_mode) : mode_q;
      wrap    = (div_q != '0) && (cnt_q == (div_q - CNT_W'(1)));

      cnt_d  = cnt_q;
      div_d  = div_q;
      tick_d = 1'b0;
      out_d  = out_q;

      if (sync) begin
         // div_p_d already carries a same-edge write, so it lands in both.
         cnt_d = '0;
         out_d = 1'b0;
         div_d = div_p_d;
      end else if (div_q == '0) begin
         // Disabled: no period in flight, so a new divisor is taken at once.
         cnt_d = '0;
         out_d = 1'b0;
         if (cfg_we) begin
            div_d = cfg_div;
         end
      end else if (!ena) begin
         // Counter and toggle waveform freeze; a pulse output cannot be held.
         if (mode_q == DIV_PULSE) begin
            out_d = 1'b0;
         end
      end else if (wrap) begin
         // Period boundary: the only point where an active divisor may change.
         cnt_d  = '0;
         tick_d = 1'b1;
         div_d  = div_p_d;
         out_d  = (mode_q == DIV_PULSE) ? 1'b1 : ~out_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
         if (mode_q == DIV_PULSE) begin
            out_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         div_q   <= RST_DIV;
         div_p_q <= RST_DIV;
         mode_q  <= DIV_TOGGLE;
         tick_q  <= 1'b0;
         out_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         div_p_q <= div_p_d;
         mode_q  <= mode_d;
         tick_q  <= tick_d;
         out_q   <= out_d;
      end
   end

   assign tick    = tick_q;
   assign div_out = out_q;

endmodule

// File: rtl/clk_div_bank.sv
// -----------------------------------------------------------------------------
// clk_div_bank
// NUM_CH independent programmable clock-divider channels plus a masked AND
// combiner. Everything runs on clk; no derived clocks.
// Ports:
//   clk      in  sole clock, rising edge
//   rst_n    in  asynchronous active-low reset
//   ena      in  global count enable
//   sync     in  synchronous phase restart of all channels
//   cfg_we   in  configuration write strobe
//   cfg_ch   in  target channel (writes to cfg_ch >= NUM_CH are dropped)
//   cfg_div  in  new divisor, 0 disables the channel
//   cfg_mode in  0 toggle, 1 pulse
//   and_mask in  channels that participate in and_out
//   tick     out per-channel one-cycle strobe
//   div_out  out per-channel divided waveform
//   and_out  out registered AND of the masked div_out bits
// -----------------------------------------------------------------------------
module clk_div_bank
   import clk_div_pkg::*;
#(
   parameter  int NUM_CH = 4,
   parameter  int CNT_W  = 8,
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              sync,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   input  logic              cfg_mode,
   input  logic [NUM_CH-1:0] and_mask,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] div_out,
   output logic              and_out
);

   localparam bit NUM_CH_LEGAL = num_ch_ok(NUM_CH, CNT_W);

   if (!NUM_CH_LEGAL) begin : g_bad_num_ch
      $error("clk_div_bank: NUM_CH must be in 1..CNT_W");
   end

   logic [NUM_CH-1:0] wr_sel;
   logic              and_q, and_d;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      // Out-of-range channel numbers match no instance, so they are ignored.
      assign wr_sel[gi] = cfg_we && (cfg_ch == CH_W'(gi));

      clk_div_chan #(
         .CNT_W   (CNT_W),
         .RST_DIV (CNT_W'(rst_div(unsigned'(gi))))
      ) u_chan (
         .clk      (clk),
         .rst_n    (rst_n),
         .ena      (ena),
         .sync     (sync),
         .cfg_we   (wr_sel[gi]),
         .cfg_div  (cfg_div),
         .cfg_mode (cfg_mode),
         .tick     (tick[gi]),
         .div_out  (div_out[gi])
      );
   end

   // An empty mask would make the AND trivially true; force it low instead.
   always_comb begin
      and_d = (and_mask != '0) && (&(div_out | ~and_mask));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         and_q <= 1'b0;
      end else begin
         and_q <= and_d;
      end
   end

   assign and_out = and_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// -----------------------------------------------------------------------------
// tb_clk_div_bank
// Directed bench for clk_div_bank. A second, 3-channel instance shares the
// stimulus so that a write to channel 3 is out of range for it.
// -----------------------------------------------------------------------------
module tb_clk_div_bank;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       ena = 1'b0;
   logic       sync = 1'b0;
   logic       cfg_we = 1'b0;
   logic [1:0] cfg_ch = '0;
   logic [7:0] cfg_div = '0;
   logic       cfg_mode = 1'b0;
   logic [3:0] and_mask = 4'b0101;
   logic [3:0] tick, div_out;
   logic       and_out;
   logic [2:0] tick3, div_out3;
   logic       and_out3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   clk_div_bank #(.NUM_CH(4), .CNT_W(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .sync     (sync),
      .cfg_we   (cfg_we),
      .cfg_ch   (cfg_ch),
      .cfg_div  (cfg_div),
      .cfg_mode (cfg_mode),
      .and_mask (and_mask),
      .tick     (tick),
      .div_out  (div_out),
      .and_out  (and_out)
   );

   clk_div_bank #(.NUM_CH(3), .CNT_W(8)) dut3 (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .sync     (sync),
      .cfg_we   (cfg_we),
      .cfg_ch   (cfg_ch),
      .cfg_div  (cfg_div),
      .cfg_mode (cfg_mode),
      .and_mask (and_mask[2:0]),
      .tick     (tick3),
      .div_out  (div_out3),
      .and_out  (and_out3)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one rising edge and settle past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [1:0] ch, input logic [7:0] dv, input logic md);
      cfg_we   = 1'b1;
      cfg_ch   = ch;
      cfg_div  = dv;
      cfg_mode = md;
      $display("[%0t] cfg write ch=%0d div=%0d mode=%0d", $time, ch, dv, md);
   endtask

   // Asynchronous reset asserted between edges; outputs must clear without a clock.
   task automatic do_reset(input string tag);
      #3;
      rst_n  = 1'b0;
      ena    = 1'b0;
      sync   = 1'b0;
      cfg_we = 1'b0;
      #1;
      check_val({tag, "_rst_tick"},  32'(tick),     32'h0);
      check_val({tag, "_rst_dout"},  32'(div_out),  32'h0);
      check_val({tag, "_rst_and"},   32'(and_out),  32'h0);
      check_val({tag, "_rst_tick3"}, 32'(tick3),    32'h0);
      check_val({tag, "_rst_dout3"}, 32'(div_out3), 32'h0);
      step();
      step();
      rst_n = 1'b1;
      $display("[%0t] reset released (%s)", $time, tag);
   endtask

   // Reset divisors 1/2/4/8: after edge k, div_out[i] is bit i of k and
   // tick[i] is set when the low i bits of k are all zero.
   task automatic run_default(input string tag, input int n, input bit chk_main);
      logic [3:0] et, ed, prev_d;
      logic       ea;
      prev_d = 4'b0000;
      for (int k = 1; k <= n; k++) begin
         step();
         if (k == 1) cfg_we = 1'b0;
         for (int i = 0; i < 4; i++) begin
            et[i] = ((k & ((1 << i) - 1)) == 0);
         end
         ed = 4'(k);
         ea = prev_d[0] & prev_d[2];
         if (chk_main) begin
            check_val({tag, "_tick"}, 32'(tick),    32'(et));
            check_val({tag, "_dout"}, 32'(div_out), 32'(ed));
            check_val({tag, "_and"},  32'(and_out), 32'(ea));
         end
         check_val({tag, "_tick3"}, 32'(tick3),    32'(et[2:0]));
         check_val({tag, "_dout3"}, 32'(div_out3), 32'(ed[2:0]));
         check_val({tag, "_and3"},  32'(and_out3), 32'(ea));
         prev_d = ed;
      end
   endtask

   initial begin
      int nt;
      logic et, ed;

      // Reset pattern: div2/4/8/16 chain, mask 0101 on and_out.
      do_reset("s1");
      ena = 1'b1;
      run_default("s1", 32, 1'b1);

      // ch1 divisor 5 written mid-period: period in flight finishes at edge 2.
      do_reset("s2");
      ena = 1'b1;
      cfg_write(2'd1, 8'd5, 1'b0);
      for (int k = 1; k <= 17; k++) begin
         step();
         if (k == 1) cfg_we = 1'b0;
         et = (k == 2) || ((k > 2) && (((k - 2) % 5) == 0));
         nt = (k >= 2) ? 1 + (k - 2) / 5 : 0;
         check_val("s2_tick1", 32'(tick[1]),    32'(et));
         check_val("s2_dout1", 32'(div_out[1]), 32'(nt % 2));
      end

      // ch2 disabled at its next wrap, then re-enabled with divisor 3.
      do_reset("s3");
      ena = 1'b1;
      cfg_write(2'd2, 8'd0, 1'b0);
      for (int k = 1; k <= 12; k++) begin
         step();
         if (k == 1) cfg_we = 1'b0;
         if (k == 8) cfg_write(2'd2, 8'd3, 1'b0);
         if (k == 9) cfg_we = 1'b0;
         et = (k == 4) || (k == 12);
         check_val("s3_tick2", 32'(tick[2]),    32'(et));
         check_val("s3_dout2", 32'(div_out[2]), 32'(et));
      end

      // ch0 pulse mode, divisor 3, ena low for edges 6..9.
      do_reset("s4");
      ena = 1'b1;
      cfg_write(2'd0, 8'd3, 1'b1);
      for (int k = 1; k <= 17; k++) begin
         step();
         if (k == 1) cfg_we = 1'b0;
         if (k == 5) ena = 1'b0;
         if (k == 9) ena = 1'b1;
         et = (k == 1) || (k == 4) || (k == 11) || (k == 14) || (k == 17);
         ed = et;
         check_val("s4_tick0", 32'(tick[0]),    32'(et));
         check_val("s4_dout0", 32'(div_out[0]), 32'(ed));
      end

      // sync with a same-edge write of divisor 7 to ch3.
      do_reset("s5");
      ena = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         step();
         if (k == 5) begin
            sync = 1'b1;
            cfg_write(2'd3, 8'd7, 1'b0);
         end
         if (k == 6) begin
            sync   = 1'b0;
            cfg_we = 1'b0;
            check_val("s5_sync_tick", 32'(tick),    32'h0);
            check_val("s5_sync_dout", 32'(div_out), 32'h0);
         end
         if (k >= 7) begin
            check_val("s5_tick3", 32'(tick[3]), 32'(k == 13));
         end
      end
      check_val("s5_dout3", 32'(div_out[3]), 32'h1);

      // Channel-3 write is out of range for the 3-channel instance; then an
      // asynchronous reset mid-period restores every divisor.
      do_reset("s6");
      ena = 1'b1;
      cfg_write(2'd3, 8'd1, 1'b1);
      run_default("s6", 6, 1'b0);
      do_reset("s7");
      ena = 1'b1;
      run_default("s7", 20, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised, fully synchronous clock-divider bank: NUM_CH independent channels, each with a runtime-programmable divisor, a one-cycle `tick` strobe and a toggle- or pulse-mode output, plus a masked AND combiner. All state runs on the single `clk`, with no ripple-clocked flops. Sits between the top-level pin wrapper and any logic needing slow strobes or divided waveforms. Reset state reproduces the fixed div2/4/8/16 chain in toggle mode.

## Interface
- `NUM_CH`, default 4: number of channels; legal range 1..CNT_W.
- `CNT_W`, default 8: divisor/counter width.
- `clk`  in  1  sole clock; all flops on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  global count enable.
- `sync`  in  1  synchronous phase restart of all channels.
- `cfg_we`  in  1  configuration write strobe.
- `cfg_ch`  in  $clog2(NUM_CH) (min 1)  target channel.
- `cfg_div`  in  CNT_W  new divisor; 0 = channel disabled.
- `cfg_mode`  in  1  0 = toggle, 1 = pulse.
- `and_mask`  in  NUM_CH  channels included in `and_out`.
- `tick`  out  NUM_CH  one-cycle strobe per channel period.
- `div_out`  out  NUM_CH  divided waveform per channel.
- `and_out`  out  1  registered AND of masked `div_out`.

## Operation
- Per channel: active divisor `div_q`, pending divisor `div_p`, mode `mode_q`, counter `cnt`, all CNT_W bits except mode.
- Reset values:
  - `cnt = 0`
  - `div_q = div_p = 2^i` for channel i
  - `mode_q = toggle`
  - `tick = 0`, `div_out = 0`, `and_out = 0`
- Priority on each edge: `sync` > (`ena == 0`) > count.
- Count step, when `ena = 1`, `div_q != 0` and `sync = 0`:
  - If `cnt == div_q-1`: `cnt <= 0`, `tick <= 1`, `div_q <= div_p`.
  - Otherwise: `cnt <= cnt+1`, `tick <= 0`.
- Output by mode:
  - Toggle mode: `div_out` inverts on every edge that sets `tick`. Output period is `2*div_q` cycles.
  - Pulse mode: `div_out <= tick`-next, i.e. identical to `tick`.
- `ena = 0`: `cnt`, `div_out` hold (toggle mode); `tick <= 0`; pulse-mode `div_out <= 0`.
- `div_q == 0` (disabled): `cnt <= 0`, `tick <= 0`, `div_out <= 0`.
- Config write (`cfg_we`, `cfg_ch < NUM_CH`):
  - Writes `div_p` and `mode_q` on that edge.
  - If the channel is disabled, or wraps on the same edge, `div_q <= cfg_div` directly (forwarding).
  - Writes with `cfg_ch >= NUM_CH` are ignored.
- Mode change takes effect on the next edge. Switching to pulse mode clears `div_out` on that edge.
- `sync`: all channels get `cnt <= 0`, `tick <= 0`, `div_out <= 0`, `div_q <= div_p`. A config write on the same edge lands in both `div_p` and `div_q`.
- `and_out <= &(div_out | ~and_mask)` when `and_mask != 0`, else 0.
- Arithmetic: unsigned; counter never exceeds `div_q-1`; no overflow possible.

## Timing
- `tick` and `div_out` are registered, with no combinational path from inputs.
- After reset release with `ena = 1`, the first `tick` appears on edge number `div_q`, counting the first edge after release as 1.
- Divisor 1: `tick` is constant high from edge 1, and toggle output is `clk/2`.
- `and_out` lags `div_out` by exactly 1 cycle.
- New divisor latency:
  - Takes effect at the next wrap, so the current period always completes (glitch-free).
  - Takes effect immediately if the channel is disabled or on `sync`.
- Asynchronous reset mid-period clears everything immediately. Counting restarts from 0 after release.

## Structure
- Package `clk_div_pkg`:
  - `div_mode_e` enum (`DIV_TOGGLE`, `DIV_PULSE`)
  - reset-divisor function `rst_div(i) = 1 << i`
  - localparam checks on `NUM_CH <= CNT_W`
- Sub-module `clk_div_chan` holds one channel (counter, `div_q`/`div_p`, mode, `tick`, `div_out`). `clk_div_bank` generates NUM_CH instances, decodes `cfg_ch`, and owns the `and_out` register.

## Test plan
- Reset, `ena = 1`, NUM_CH = 4, no writes -> `div_out[0..3]` periods 2/4/8/16 cycles, `tick[3]` every 8 cycles; mask `4'b0101` -> `and_out` matches `div_out[0] & div_out[2]` delayed 1 cycle.
- Write ch1 `div = 5` mid-period -> current 2-cycle period completes, then `tick[1]` every 5 cycles, `div_out[1]` period 10.
- Write ch2 `div = 0` -> `div_out[2]`/`tick[2]` low from the next wrap. Then write `div = 3` -> first `tick[2]` 3 edges later.
- Pulse mode on ch0 with `div = 3`, toggle `ena` low for 4 cycles mid-count -> `tick` suppressed, `cnt` frozen; count resumes without skipped or extra ticks.
- Assert `sync` with a same-cycle write ch3 `div = 7` -> all outputs 0 next cycle, `tick[3]` exactly 7 edges after `sync`.
- Assert `rst_n` low asynchronously mid-period, and write `cfg_ch = NUM_CH` -> all outputs 0 without a clock edge, divisors back to `2^i`; the out-of-range write changes nothing.
